// File: rtl/regwrite_seq_pkg.sv
// rtl/regwrite_seq_pkg.sv - shared encodings for the register write-back sequencer
//
// Purpose: FSM state encoding, default memory timeout and write-source
// select values shared by regwrite_seq and its access timer.
package regwrite_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_MEM_WR = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/regwrite_seq_access_timer.sv
// rtl/regwrite_seq_access_timer.sv - 8-bit watchdog counter for outstanding memory accesses
//
// Purpose: counts cycles spent waiting on the data memory and flags when the
// current cycle is the last one allowed.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the counter (held while no access is outstanding)
//   enable     : count this cycle
//   expired    : the edge ending this cycle is the TIMEOUT-th edge in the access
module access_timer
  import regwrite_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of edges already spent in the access, so the
  // abort edge is the one seen while count == TIMEOUT-1.
  assign expired = enable && (count >= 8'(TIMEOUT - 1));

endmodule

// File: rtl/regwrite_seq.sv
// rtl/regwrite_seq.sv - register write-back sequencer with data-memory handshake
//
// Purpose: chooses ALU or memory data for the register file write, runs the
// read/write request handshake with the multi-cycle data memory and stalls
// the CPU while an access is outstanding.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   instr_valid       : decoded instruction valid
//   is_load, is_store : memory load / store instruction
//   write_req         : ALU result register write requested
//   dest_addr         : destination register
//   mem_busywait      : data memory busy
//   mem_read/mem_write: data memory requests
//   writesel          : 1 = memory data, 0 = ALU result
//   reg_writeenable   : register file write enable
//   reg_writeaddr     : register file write address
//   cpu_stall         : freeze PC / fetch
//   mem_err           : sticky memory timeout flag
module regwrite_seq
  import regwrite_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              mem_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic              writesel,
  output logic              reg_writeenable,
  output logic [ADDR_W-1:0] reg_writeaddr,
  output logic              cpu_stall,
  output logic              mem_err
);

  state_t            state;
  logic [ADDR_W-1:0] dest_q;
  logic              in_access;
  logic              expired;

  assign in_access = (state == ST_MEM_RD) || (state == ST_MEM_WR);

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_access),
    .enable  (in_access),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      dest_q  <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A load wins over a simultaneous store flag.
          if (instr_valid && is_load) begin
            dest_q <= dest_addr;
            state  <= ST_MEM_RD;
          end else if (instr_valid && is_store) begin
            state <= ST_MEM_WR;
          end
        end
        ST_MEM_RD: begin
          // Completion takes priority over a timeout on the same edge.
          if (!mem_busywait) begin
            state <= ST_WB;
          end else if (expired) begin
            state   <= ST_IDLE;
            mem_err <= 1'b1;
          end
        end
        ST_MEM_WR: begin
          if (!mem_busywait) begin
            state <= ST_IDLE;
          end else if (expired) begin
            state   <= ST_IDLE;
            mem_err <= 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; everything is forced low while reset is held so the
  // combinational IDLE paths cannot leak a write during reset.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    writesel        = SEL_ALU;
    reg_writeenable = 1'b0;
    reg_writeaddr   = '0;
    cpu_stall       = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (instr_valid && (is_load || is_store)) begin
            cpu_stall = 1'b1;
          end else if (instr_valid && write_req) begin
            reg_writeenable = 1'b1;
            reg_writeaddr   = dest_addr;
          end
        end
        ST_MEM_RD: begin
          mem_read  = 1'b1;
          cpu_stall = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          cpu_stall = 1'b1;
        end
        ST_WB: begin
          writesel        = SEL_MEM;
          reg_writeenable = 1'b1;
          reg_writeaddr   = dest_q;
          cpu_stall       = 1'b1;
        end
        default: begin
          cpu_stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regwrite_seq.md
Name: regwrite_seq

Overview:
- Sequences the register write-back path of the 8-bit single-cycle processor.
- Decides each cycle whether the register file is written from the ALU result or from data-memory read data. Drives the write-source select, write enable and write address.
- Runs the read/write handshake with the multi-cycle data memory and stalls the CPU while a memory access is outstanding.
- Sits between the control unit, the data memory, and the write-source mux in front of the register file.

Parameters:
- TIMEOUT, 255: maximum cycles spent in a memory state before the access is aborted; valid range 2..255.
- ADDR_W, 3: register-file address width (8 registers).

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTR_VALID  in  1  decoded instruction valid this cycle.
- IS_LOAD  in  1  instruction is a memory load (lwd/lwi).
- IS_STORE  in  1  instruction is a memory store (swd/swi).
- WRITE_REQ  in  1  instruction writes the register file from the ALU.
- DEST_ADDR  in  ADDR_W  destination register of the instruction.
- MEM_BUSYWAIT  in  1  data memory busy; asserted by memory while an access is in progress.
- MEM_READ  out  1  data memory read request.
- MEM_WRITE  out  1  data memory write request.
- WRITESEL  out  1  write-source select: 1 = memory read data, 0 = ALU result.
- REG_WRITEENABLE  out  1  register-file write enable for this clock edge.
- REG_WRITEADDR  out  ADDR_W  register-file write address.
- CPU_STALL  out  1  freeze PC/instruction fetch.
- MEM_ERR  out  1  sticky flag: a memory access timed out.

Behaviour:
- Reset (asynchronous, any time): state=IDLE, latched destination=0, timeout counter=0, MEM_ERR=0.
  - All outputs 0 while RESET is high.
  - An access in flight is abandoned with no register write.
- States:
  - IDLE: no access in flight.
  - MEM_RD: read outstanding.
  - MEM_WR: write outstanding.
  - WB: load write-back.
- IDLE:
  - ALU write: INSTR_VALID & WRITE_REQ & ~IS_LOAD & ~IS_STORE gives REG_WRITEENABLE=1, WRITESEL=0, REG_WRITEADDR=DEST_ADDR. All three are combinational, so latency is 0 and the write lands on the same edge.
  - INSTR_VALID & IS_LOAD: latch DEST_ADDR, go to MEM_RD. CPU_STALL=1 combinationally in this cycle.
  - INSTR_VALID & IS_STORE: go to MEM_WR. CPU_STALL=1 combinationally in this cycle.
  - IS_LOAD and IS_STORE both high: treated as a load.
  - WRITE_REQ is ignored when either memory flag is set.
- MEM_RD:
  - MEM_READ=1, CPU_STALL=1, REG_WRITEENABLE=0.
  - The counter increments each cycle in this state.
  - MEM_BUSYWAIT sampled low at a rising edge: go to WB.
  - This includes the first cycle, i.e. a 1-cycle memory.
- MEM_WR:
  - MEM_WRITE=1, CPU_STALL=1.
  - MEM_BUSYWAIT low at an edge: go to IDLE.
  - CPU_STALL deasserts in the following cycle.
- WB:
  - Exactly 1 cycle.
  - WRITESEL=1, REG_WRITEENABLE=1, REG_WRITEADDR=latched destination.
  - CPU_STALL=1 so the load instruction completes with the write edge.
  - Then go to IDLE.
- Load latency: issue cycle, then at least 1 MEM_RD cycle, then 1 WB cycle. Minimum stall is 3 cycles.
- Timeout:
  - The counter clears on entry to MEM_RD/MEM_WR.
  - If the counter reaches TIMEOUT while MEM_BUSYWAIT is still high: go to IDLE, set MEM_ERR=1, no register write.
  - MEM_ERR is cleared only by RESET.
- Request hold: MEM_READ and MEM_WRITE are never both high. Each stays asserted continuously until completion or timeout.
- Inputs from the control unit are ignored outside IDLE, because the instruction is frozen by CPU_STALL.
- WRITESEL is 0 in every state except WB.

Decomposition:
- Shared package/defines file:
  - state encodings (IDLE=2'd0, MEM_RD=2'd1, MEM_WR=2'd2, WB=2'd3);
  - TIMEOUT default;
  - WRITESEL constants SEL_ALU=0, SEL_MEM=1.
- One natural sub-module, access_timer: an 8-bit counter with clear, enable and an expired output, used for the timeout.
- The FSM and output decode stay in regwrite_seq.

Test Plan:
- ALU write, no memory:
  - Stimulus: INSTR_VALID=1, WRITE_REQ=1, DEST_ADDR=3'd5.
  - Required: same cycle REG_WRITEENABLE=1, WRITESEL=0, REG_WRITEADDR=5, CPU_STALL=0.
- Load, memory busy 4 cycles:
  - Stimulus: IS_LOAD=1, DEST_ADDR=3'd2; MEM_BUSYWAIT high for 4 edges, then low.
  - Required: MEM_READ high for 5 cycles, then 1 WB cycle with WRITESEL=1, REG_WRITEENABLE=1, REG_WRITEADDR=2.
  - Required: CPU_STALL high for 7 cycles, then 0.
- Store:
  - Stimulus: IS_STORE=1; MEM_BUSYWAIT high for 2 edges.
  - Required: MEM_WRITE high for 3 cycles, REG_WRITEENABLE never 1, back in IDLE after the 4th edge.
- Timeout:
  - Stimulus: TIMEOUT=8, load with MEM_BUSYWAIT stuck high.
  - Required: after 8 cycles in MEM_RD, MEM_READ drops, MEM_ERR=1 and stays 1, no register write occurs.
  - Required: a following ALU write still works.
- Reset mid-access:
  - Stimulus: assert RESET asynchronously (between clock edges) during MEM_RD.
  - Required: all outputs 0 immediately; after release, state is IDLE, MEM_ERR=0, no WB cycle.
- Back-to-back load then ALU write:
  - Stimulus: load to r1 (1-cycle memory), then ALU write to r1 on the first unstalled cycle.
  - Required: WB writes r1 with WRITESEL=1, next cycle writes r1 with WRITESEL=0.
